// File: rtl/mm_read_master.sv
// Avalon-MM pipelined read master buffering returned words in a show-ahead FIFO.
// Define MM_READ_MASTER_STATS_EN to add the stat_words / stat_stall counters.
module mm_read_master #(
    parameter int ADDRESSWIDTH    = 28,
    parameter int DATAWIDTH       = 32,
    parameter int BYTEENABLEWIDTH = 4,
    parameter int FIFO_DEPTH      = 32,
    parameter int FIFO_DEPTH_LOG2 = 5
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       control_fixed_location,
    input  logic [ADDRESSWIDTH-1:0]    control_read_base,
    input  logic [ADDRESSWIDTH-1:0]    control_read_length,
    input  logic                       control_go,
    output logic                       control_done,
    input  logic                       user_read_buffer,
    output logic [DATAWIDTH-1:0]       user_buffer_output_data,
    output logic                       user_data_available,
    output logic [ADDRESSWIDTH-1:0]    master_address,
    output logic                       master_read,
    output logic [BYTEENABLEWIDTH-1:0] master_byteenable,
    input  logic [DATAWIDTH-1:0]       master_readdata,
    input  logic                       master_readdatavalid,
    input  logic                       master_waitrequest
`ifdef MM_READ_MASTER_STATS_EN
    ,
    output logic [31:0]                stat_words,
    output logic [31:0]                stat_stall
`endif
);

    localparam int PW = FIFO_DEPTH_LOG2 + 1;
    localparam int SW = FIFO_DEPTH_LOG2 + 2;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t                     state_q, state_d;
    logic [ADDRESSWIDTH-1:0]    addr_q, addr_d;
    logic [ADDRESSWIDTH-1:0]    rem_q, rem_d;
    logic [ADDRESSWIDTH-1:0]    len_words;
    logic [PW-1:0]              pend_q, pend_d;
    logic [PW-1:0]              used_q, used_d;
    logic [FIFO_DEPTH_LOG2-1:0] wptr_q, wptr_d;
    logic [FIFO_DEPTH_LOG2-1:0] rptr_q, rptr_d;
    logic                       fixed_q, fixed_d;
    logic                       read_q, read_d;
    logic                       done_q, done_d;
    logic                       accept, push, pop;
    logic [DATAWIDTH-1:0]       mem_q [FIFO_DEPTH];

    assign len_words = control_read_length / ADDRESSWIDTH'(BYTEENABLEWIDTH);
    assign accept    = read_q && !master_waitrequest;
    // Returns arriving with nothing outstanding are leftovers from before reset.
    assign push      = master_readdatavalid && (pend_q != '0);
    assign pop       = user_read_buffer && (used_q != '0);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        fixed_d = fixed_q;
        pend_d  = pend_q + PW'(accept) - PW'(push);
        used_d  = used_q + PW'(push) - PW'(pop);
        wptr_d  = wptr_q + FIFO_DEPTH_LOG2'(push);
        rptr_d  = rptr_q + FIFO_DEPTH_LOG2'(pop);
        if (accept) begin
            rem_d = rem_q - ADDRESSWIDTH'(1);
            if (!fixed_q) begin
                addr_d = addr_q + ADDRESSWIDTH'(BYTEENABLEWIDTH);
            end
        end
        unique case (state_q)
            IDLE: begin
                if (control_go && (len_words != '0)) begin
                    state_d = BUSY;
                    addr_d  = control_read_base;
                    rem_d   = len_words;
                    fixed_d = control_fixed_location;
                end
            end
            BUSY: begin
                if ((rem_q == '0) && (pend_q == '0)) begin
                    state_d = IDLE;
                end
            end
        endcase
        done_d = (state_d == IDLE);
        // Only issue when the word is guaranteed a FIFO slot on return.
        read_d = (state_d == BUSY) && (rem_d != '0)
              && ((SW'(used_d) + SW'(pend_d)) < SW'(FIFO_DEPTH));
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            pend_q  <= '0;
            used_q  <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            fixed_q <= 1'b0;
            read_q  <= 1'b0;
            done_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            pend_q  <= pend_d;
            used_q  <= used_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            fixed_q <= fixed_d;
            read_q  <= read_d;
            done_q  <= done_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q] <= master_readdata;
        end
    end

    assign control_done            = done_q;
    assign master_read             = read_q;
    assign master_address          = addr_q;
    assign master_byteenable       = '1;
    assign user_data_available     = (used_q != '0);
    assign user_buffer_output_data = (used_q != '0) ? mem_q[rptr_q] : '0;

`ifdef MM_READ_MASTER_STATS_EN
    logic [31:0] words_q, stall_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            words_q <= '0;
            stall_q <= '0;
        end else begin
            words_q <= words_q + 32'(push);
            stall_q <= stall_q + 32'(read_q && master_waitrequest);
        end
    end

    assign stat_words = words_q;
    assign stat_stall = stall_q;
`endif

endmodule

// File: tb/tb_mm_read_master.sv
// Randomised scoreboard bench for mm_read_master with an Avalon slave model.
// Expected addresses/data are queued at issue; a monitor compares on DUT events.
module tb_mm_read_master;

    localparam int AW    = 28;
    localparam int DW    = 32;
    localparam int BEW   = 4;
    localparam int DEPTH = 32;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic           control_fixed_location = 1'b0;
    logic [AW-1:0]  control_read_base = '0;
    logic [AW-1:0]  control_read_length = '0;
    logic           control_go = 1'b0;
    logic           control_done;
    logic           user_read_buffer = 1'b0;
    logic [DW-1:0]  user_buffer_output_data;
    logic           user_data_available;
    logic [AW-1:0]  master_address;
    logic           master_read;
    logic [BEW-1:0] master_byteenable;
    logic [DW-1:0]  master_readdata = '0;
    logic           master_readdatavalid = 1'b0;
    logic           master_waitrequest = 1'b0;
`ifdef MM_READ_MASTER_STATS_EN
    logic [31:0]    stat_words;
    logic [31:0]    stat_stall;
`endif

    mm_read_master dut (
        .clk                     (clk),
        .reset                   (reset),
        .control_fixed_location  (control_fixed_location),
        .control_read_base       (control_read_base),
        .control_read_length     (control_read_length),
        .control_go              (control_go),
        .control_done            (control_done),
        .user_read_buffer        (user_read_buffer),
        .user_buffer_output_data (user_buffer_output_data),
        .user_data_available     (user_data_available),
        .master_address          (master_address),
        .master_read             (master_read),
        .master_byteenable       (master_byteenable),
        .master_readdata         (master_readdata),
        .master_readdatavalid    (master_readdatavalid),
        .master_waitrequest      (master_waitrequest)
`ifdef MM_READ_MASTER_STATS_EN
        ,
        .stat_words              (stat_words),
        .stat_stall              (stat_stall)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    // Knobs set by the stimulus, read by the slave/user model.
    int wait_pct = 0;
    int lat_min = 1;
    int lat_max = 1;
    int pop_pct = 0;
    bit pop_en = 1'b0;
    int force_wait = 0;
    int force_issued = 0;

    typedef struct {
        int            due;
        logic [DW-1:0] d;
    } ret_t;

    ret_t          ret_q[$];
    logic [AW-1:0] exp_addr[$];
    logic [DW-1:0] exp_data[$];
    int            last_due = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    // Avalon slave and user-side pop driver.
    always @(negedge clk) begin
        logic          acc;
        logic [DW-1:0] d;
        int            due;
        if (master_read && force_issued < force_wait) begin
            master_waitrequest = 1'b1;
            force_issued++;
        end else begin
            master_waitrequest = ($urandom_range(0, 99) < wait_pct);
        end
        acc = master_read && !master_waitrequest;
        if (acc) begin
            d = $urandom;
            exp_data.push_back(d);
            due = cyc + $urandom_range(lat_min, lat_max);
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            ret_q.push_back('{due, d});
        end
        if (ret_q.size() != 0 && ret_q[0].due <= cyc) begin
            master_readdatavalid = 1'b1;
            master_readdata = ret_q[0].d;
            void'(ret_q.pop_front());
        end else begin
            master_readdatavalid = 1'b0;
            master_readdata = $urandom;
        end
        user_read_buffer = pop_en && ($urandom_range(0, 99) < pop_pct);
    end

    // Reference model state: words left to issue, outstanding, buffered.
    bit          m_busy = 1'b0;
    int          m_rem = 0;
    int          m_pend = 0;
    int          m_cnt = 0;
    logic [31:0] m_words = '0;
    logic [31:0] m_stall = '0;

    always @(negedge clk) begin
        bit acc, push, pop, was_busy;
        int words;
        #2;
        acc = master_read && !master_waitrequest;
        chk("done", control_done, !m_busy);
        chk("read", master_read,
            m_busy && m_rem != 0 && (m_cnt + m_pend) < DEPTH);
        chk("avail", user_data_available, m_cnt != 0);
        if (m_cnt == 0) chk("data_empty", user_buffer_output_data, 0);
`ifdef MM_READ_MASTER_STATS_EN
        chk("stat_words", stat_words, m_words);
        chk("stat_stall", stat_stall, m_stall);
`endif
        if (master_read) begin
            if (exp_addr.size() == 0) begin
                chk("unexpected_read", master_read, 0);
            end else begin
                chk("addr", master_address, exp_addr[0]);
                if (acc) void'(exp_addr.pop_front());
            end
        end
        pop = user_read_buffer && m_cnt != 0;
        if (pop) begin
            if (exp_data.size() == 0)
                chk("unexpected_data", user_data_available, 0);
            else
                chk("data", user_buffer_output_data, exp_data.pop_front());
        end
        if (!reset) begin
            m_busy = 1'b0;
            m_rem = 0;
            m_pend = 0;
            m_cnt = 0;
            m_words = '0;
            m_stall = '0;
            exp_addr.delete();
            exp_data.delete();
        end else begin
            was_busy = m_busy;
            push = master_readdatavalid && m_pend != 0;
            if (was_busy && m_rem == 0 && m_pend == 0) m_busy = 1'b0;
            m_pend += int'(acc) - int'(push);
            m_rem -= int'(acc);
            m_cnt += int'(push) - int'(pop);
            m_words += 32'(push);
            m_stall += 32'(master_read && master_waitrequest);
            words = int'(control_read_length / BEW);
            if (control_go && !was_busy && words != 0) begin
                m_busy = 1'b1;
                m_rem = words;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic start(input logic [AW-1:0] base,
                         input logic [AW-1:0] len, input bit fx);
        int w;
        logic [AW-1:0] a;
        w = int'(len / BEW);
        for (int i = 0; i < w; i++) begin
            a = fx ? base : base + AW'(BEW * i);
            exp_addr.push_back(a);
        end
        control_read_base = base;
        control_read_length = len;
        control_fixed_location = fx;
        control_go = 1'b1;
        tick(1);
        control_go = 1'b0;
    endtask

    // A go that must be ignored: only driven while the DUT reports busy.
    task automatic go_busy();
        if (control_done == 1'b0) begin
            control_read_base = AW'($urandom);
            control_read_length = AW'($urandom_range(4, 400));
            control_fixed_location = $urandom_range(0, 1) == 1;
            control_go = 1'b1;
            tick(1);
            control_go = 1'b0;
        end
    endtask

    task automatic wait_idle(input int bound, input bit need_empty);
        int n;
        n = 0;
        while (!(control_done && (!need_empty ||
               (exp_data.size() == 0 && ret_q.size() == 0)))
               && n < bound) begin
            tick(1);
            n++;
        end
        chk("idle_timeout", n < bound, 1);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [AW-1:0] b;
        reset = 1'b0;
        tick(3);
        chk("rst_done", control_done, 1);
        chk("rst_read", master_read, 0);
        chk("rst_addr", master_address, 0);
        chk("rst_avail", user_data_available, 0);
        chk("rst_data", user_buffer_output_data, 0);
        chk("byteenable", master_byteenable, 4'hF);
        reset = 1'b1;
        tick(2);

        // Single word, fixed 2-cycle latency.
        pop_en = 1'b1;
        pop_pct = 100;
        lat_min = 2;
        lat_max = 2;
        start(28'h8000000, 28'd4, 1'b0);
        wait_idle(500, 1'b1);

        // 24-word burst, no stalls, partial popping.
        pop_pct = 50;
        lat_min = 1;
        lat_max = 3;
        start(28'h8000004, 28'd96, 1'b0);
        wait_idle(2000, 1'b1);

        // No pops: all buffered, then issue halts when the FIFO is reserved.
        pop_en = 1'b0;
        start(28'h8000004, 28'd96, 1'b0);
        wait_idle(2000, 1'b0);
        tick(2);
        chk("buffered_avail", user_data_available, 1);
        start(28'h0001000, 28'd64, 1'b0);
        tick(60);
        chk("full_read_off", master_read, 0);
        chk("full_left", exp_addr.size(), 8);
        chk("full_done", control_done, 0);
        pop_en = 1'b1;
        pop_pct = 70;
        wait_idle(2000, 1'b1);

        // Stall on the first read, fixed address.
        force_wait = force_issued + 5;
        start(28'h0ABCDE0, 28'd12, 1'b1);
        wait_idle(500, 1'b1);
`ifdef MM_READ_MASTER_STATS_EN
        chk("stall5", stat_stall, 5);
`endif

        // Zero-word gos are ignored; go while busy is ignored.
        start(28'h0000100, 28'd0, 1'b0);
        tick(3);
        chk("len0_done", control_done, 1);
        start(28'h0000200, 28'd3, 1'b0);
        tick(3);
        chk("len3_done", control_done, 1);
        start(28'h0000300, 28'd40, 1'b0);
        tick(2);
        go_busy();
        tick(1);
        go_busy();
        wait_idle(1000, 1'b1);

        // Reset with reads outstanding; stale returns must be dropped.
        lat_min = 10;
        lat_max = 10;
        start(28'h0002000, 28'd12, 1'b0);
        n = 0;
        while (exp_addr.size() != 0 && n < 100) begin
            tick(1);
            n++;
        end
        chk("t6_issue_timeout", n < 100, 1);
        reset = 1'b0;
        tick(2);
        reset = 1'b1;
        n = 0;
        while (ret_q.size() != 0 && n < 100) begin
            tick(1);
            n++;
        end
        tick(3);
        chk("stale_avail", user_data_available, 0);
        chk("stale_done", control_done, 1);

        // Randomised transfers, some wrapping the address space.
        for (int k = 0; k < 40; k++) begin
            wait_pct = $urandom_range(0, 40);
            lat_min = $urandom_range(1, 3);
            lat_max = lat_min + $urandom_range(0, 3);
            pop_pct = $urandom_range(20, 100);
            b = AW'($urandom);
            if (k % 8 == 0) b = 28'hFFFFFE0 | AW'($urandom_range(0, 15));
            start(b, AW'($urandom_range(0, 200)), $urandom_range(0, 3) == 0);
            if ($urandom_range(0, 3) == 0) begin
                tick($urandom_range(1, 4));
                go_busy();
            end
            wait_idle(3000, 1'b1);
        end
        tick(5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
